// File: rtl/prf_debug_pkg.sv
// Shared types for the PRF debug-port sequencer: FSM states, byte-offset width
// and the latched whole-register request.
package prf_debug_pkg;

    localparam int PRF_PHYS_LOG = 6;
    localparam int PRF_NUM_PHYS = 48;
    localparam int PRF_BYTE_W   = 8;
    localparam int BOFS_W       = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } prf_dbg_state_e;

    typedef struct packed {
        logic                      we;
        logic [PRF_PHYS_LOG-1:0]   addr;
        logic [8*PRF_BYTE_W-1:0]   wdata;
    } prf_dbg_req_t;

endpackage

// File: rtl/prf_debug_rr_arb.sv
// Two-way round-robin arbiter; grant is combinational, zero latency, and the
// last-grant pointer only moves when the owning transaction completes.
module prf_debug_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       upd_idx_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (upd_i) begin
            last_d = upd_idx_i;
        end
    end

    // Reset value 1 makes requester 0 the winner of the first contended grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/prf_debug_seq.sv
// Serialises 64-bit PRF debug reads/writes from two requesters into byte accesses;
// write completes 9 cycles after accept, read 9+RD_LAT; new requests wait for IDLE and pipeIdle_i.
module prf_debug_seq
    import prf_debug_pkg::*;
#(
    parameter int PHYS_LOG = PRF_PHYS_LOG,
    parameter int NUM_PHYS = PRF_NUM_PHYS,
    parameter int BYTE_W   = PRF_BYTE_W,
    parameter int RD_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pipeIdle_i,
    input  logic [1:0]                   reqValid_i,
    input  logic [1:0]                   reqWe_i,
    input  logic [1:0][PHYS_LOG-1:0]     reqAddr_i,
    input  logic [1:0][8*BYTE_W-1:0]     reqWData_i,
    output logic [1:0]                   reqReady_o,
    output logic [1:0]                   respValid_o,
    output logic                         respErr_o,
    output logic [8*BYTE_W-1:0]          respRData_o,
    output logic                         busy_o,
    output logic [PHYS_LOG+BOFS_W-1:0]   debugPRFAddr_o,
    output logic [BYTE_W-1:0]            debugPRFWrData_o,
    output logic                         debugPRFWrEn_o,
    input  logic [BYTE_W-1:0]            debugPRFRdData_i
);

    localparam int CNT_W = $clog2(8 + RD_LAT + 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(7 + RD_LAT);
    localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(RD_LAT);

    prf_dbg_state_e      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    prf_dbg_req_t        req_q, req_d;
    logic                own_q, own_d;
    logic                err_q, err_d;
    logic [8*BYTE_W-1:0] rbuf_q;

    logic [1:0]          arb_gnt;
    logic                arb_upd;
    logic                gi;
    logic [BYTE_W-1:0]   wr_byte;
    logic [CNT_W-1:0]    cap_full;
    logic [BOFS_W-1:0]   cap_idx;

    prf_debug_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (reqValid_i),
        .upd_i    (arb_upd),
        .upd_idx_i(own_q),
        .gnt_o    (arb_gnt)
    );

    assign gi       = arb_gnt[1];
    assign cap_full = cnt_q - LAT_C;
    assign cap_idx  = cap_full[BOFS_W-1:0];

    always_comb begin
        wr_byte = '0;
        for (int i = 0; i < 8; i++) begin
            if (cnt_q[BOFS_W-1:0] == BOFS_W'(i)) begin
                wr_byte = req_q.wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        req_d            = req_q;
        own_d            = own_q;
        err_d            = err_q;
        arb_upd          = 1'b0;
        reqReady_o       = '0;
        respValid_o      = '0;
        respErr_o        = 1'b0;
        respRData_o      = '0;
        busy_o           = (state_q != IDLE);
        debugPRFAddr_o   = '0;
        debugPRFWrData_o = '0;
        debugPRFWrEn_o   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pipeIdle_i && (reqValid_i != 2'b00)) begin
                    reqReady_o  = arb_gnt;
                    own_d       = gi;
                    req_d.we    = reqWe_i[gi];
                    req_d.addr  = reqAddr_i[gi];
                    req_d.wdata = reqWData_i[gi];
                    // Out-of-range registers skip the port entirely and complete next cycle.
                    if ({1'b0, reqAddr_i[gi]} >= (PHYS_LOG+1)'(NUM_PHYS)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = reqWe_i[gi] ? WR : RD;
                    end
                end
            end
            WR: begin
                debugPRFAddr_o   = {req_q.addr, cnt_q[BOFS_W-1:0]};
                debugPRFWrData_o = wr_byte;
                debugPRFWrEn_o   = 1'b1;
                cnt_d            = cnt_q + 1'b1;
                if (cnt_q == BYTE_LAST) begin
                    state_d = DONE;
                end
            end
            RD: begin
                if (cnt_q <= BYTE_LAST) begin
                    debugPRFAddr_o = {req_q.addr, cnt_q[BOFS_W-1:0]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RD_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                respValid_o = own_q ? 2'b10 : 2'b01;
                respErr_o   = err_q;
                respRData_o = (err_q || req_q.we) ? '0 : rbuf_q;
                arb_upd     = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            own_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            own_q   <= own_d;
            err_q   <= err_d;
        end
    end

    // Read data trails the address by RD_LAT cycles, so byte (cnt-RD_LAT) lands now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbuf_q <= '0;
        end else if ((state_q == RD) && (cnt_q >= LAT_C)) begin
            for (int i = 0; i < 8; i++) begin
                if (cap_idx == BOFS_W'(i)) begin
                    rbuf_q[i*BYTE_W +: BYTE_W] <= debugPRFRdData_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_prf_debug_seq.sv
// Directed bench for prf_debug_seq with a byte-wide PRF model (RD_LAT = 1).
module tb_prf_debug_seq;

    localparam int NUM_PHYS = 48;

    logic             clk;
    logic             reset;
    logic             pipeIdle_i;
    logic [1:0]       reqValid_i;
    logic [1:0]       reqWe_i;
    logic [1:0][5:0]  reqAddr_i;
    logic [1:0][63:0] reqWData_i;
    logic [1:0]       reqReady_o;
    logic [1:0]       respValid_o;
    logic             respErr_o;
    logic [63:0]      respRData_o;
    logic             busy_o;
    logic [8:0]       debugPRFAddr_o;
    logic [7:0]       debugPRFWrData_o;
    logic             debugPRFWrEn_o;
    logic [7:0]       debugPRFRdData_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:NUM_PHYS*8-1];

    prf_debug_seq dut (
        .clk             (clk),
        .reset           (reset),
        .pipeIdle_i      (pipeIdle_i),
        .reqValid_i      (reqValid_i),
        .reqWe_i         (reqWe_i),
        .reqAddr_i       (reqAddr_i),
        .reqWData_i      (reqWData_i),
        .reqReady_o      (reqReady_o),
        .respValid_o     (respValid_o),
        .respErr_o       (respErr_o),
        .respRData_o     (respRData_o),
        .busy_o          (busy_o),
        .debugPRFAddr_o  (debugPRFAddr_o),
        .debugPRFWrData_o(debugPRFWrData_o),
        .debugPRFWrEn_o  (debugPRFWrEn_o),
        .debugPRFRdData_i(debugPRFRdData_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide PRF with one cycle of read latency.
    initial begin
        for (int i = 0; i < NUM_PHYS*8; i++) mem[i] = 8'h00;
        debugPRFRdData_i = 8'h00;
    end
    always @(posedge clk) begin
        if (debugPRFWrEn_o && (int'(debugPRFAddr_o) < NUM_PHYS*8))
            mem[debugPRFAddr_o] <= debugPRFWrData_o;
        if (int'(debugPRFAddr_o) < NUM_PHYS*8)
            debugPRFRdData_i <= mem[debugPRFAddr_o];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 30; c++) begin
            next();
            if (!busy_o) break;
        end
        #1;
        chk(tag, 64'(busy_o), 64'd0);
    endtask

    initial begin : stim
        logic [63:0] wd;
        logic [63:0] wd2;
        logic [1:0]  exp_g;
        int          ng;

        reset      = 1'b0;
        pipeIdle_i = 1'b0;
        reqValid_i = 2'b00;
        reqWe_i    = 2'b00;
        reqAddr_i  = '0;
        reqWData_i = '0;
        wd         = 64'h1122334455667788;
        wd2        = 64'h0807060504030201;

        // Reset state
        next(); next(); #1;
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_ready", 64'(reqReady_o), 64'd0);
        chk("rst_resp",  64'(respValid_o), 64'd0);
        chk("rst_wren",  64'(debugPRFWrEn_o), 64'd0);
        chk("rst_addr",  64'(debugPRFAddr_o), 64'd0);
        chk("rst_rdata", respRData_o, 64'd0);
        reset = 1'b1;

        // Write reg 5 from requester 0
        next();
        pipeIdle_i    = 1'b1;
        reqValid_i    = 2'b01;
        reqWe_i       = 2'b01;
        reqAddr_i[0]  = 6'd5;
        reqWData_i[0] = wd;
        #1;
        chk("wr_ready", 64'(reqReady_o), 64'h1);
        for (int k = 0; k < 8; k++) begin
            next();
            if (k == 0) reqValid_i = 2'b00;
            #1;
            chk("wr_en",   64'(debugPRFWrEn_o), 64'd1);
            chk("wr_addr", 64'(debugPRFAddr_o), 64'(8'h28 + k));
            chk("wr_data", 64'(debugPRFWrData_o), (wd >> (8*k)) & 64'hFF);
        end
        next(); #1;
        chk("wr_resp",   64'(respValid_o), 64'h1);
        chk("wr_err",    64'(respErr_o), 64'd0);
        chk("wr_rdata0", respRData_o, 64'd0);
        next(); #1;
        chk("wr_idle", 64'(busy_o), 64'd0);

        // Read reg 5 back via requester 1
        reqValid_i   = 2'b10;
        reqWe_i      = 2'b00;
        reqAddr_i[1] = 6'd5;
        #1;
        chk("rd_ready", 64'(reqReady_o), 64'h2);
        for (int k = 1; k <= 10; k++) begin
            next();
            if (k == 1) reqValid_i = 2'b00;
            #1;
            if (k <= 8) begin
                chk("rd_addr", 64'(debugPRFAddr_o), 64'(8'h28 + k - 1));
                chk("rd_wren", 64'(debugPRFWrEn_o), 64'd0);
            end
            if (k < 10) chk("rd_early", 64'(respValid_o), 64'd0);
            else begin
                chk("rd_resp",  64'(respValid_o), 64'h2);
                chk("rd_rdata", respRData_o, wd);
            end
        end

        // Both valid: grants alternate, starting at 0 since 1 was last
        reqValid_i    = 2'b11;
        reqWe_i       = 2'b11;
        reqAddr_i[0]  = 6'd10;
        reqAddr_i[1]  = 6'd11;
        reqWData_i[0] = 64'hAAAA;
        reqWData_i[1] = 64'hBBBB;
        exp_g = 2'b01;
        ng    = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            next(); #1;
            if (reqReady_o != 2'b00) begin
                chk("alt_gnt", 64'(reqReady_o), 64'(exp_g));
                exp_g = ~exp_g;
                ng++;
                next(); #1;
                chk("alt_width", 64'(reqReady_o), 64'd0);
            end
        end
        chk("alt_count", 64'(ng), 64'd4);
        reqValid_i = 2'b00;
        wait_idle("alt_idle");

        // pipeIdle gating
        pipeIdle_i    = 1'b0;
        reqValid_i    = 2'b01;
        reqWe_i       = 2'b01;
        reqAddr_i[0]  = 6'd7;
        reqWData_i[0] = 64'h5555;
        for (int c = 0; c < 3; c++) begin
            next(); #1;
            chk("gate_ready", 64'(reqReady_o), 64'd0);
            chk("gate_wren",  64'(debugPRFWrEn_o), 64'd0);
            chk("gate_busy",  64'(busy_o), 64'd0);
        end
        pipeIdle_i = 1'b1;
        #1;
        chk("gate_accept", 64'(reqReady_o), 64'h1);
        next();
        reqValid_i = 2'b00;
        #1;
        chk("gate_wr", 64'(debugPRFWrEn_o), 64'd1);
        wait_idle("gate_idle");

        // Out-of-range read from requester 0 (buffer still holds reg 5)
        reqValid_i   = 2'b01;
        reqWe_i      = 2'b00;
        reqAddr_i[0] = 6'(NUM_PHYS);
        #1;
        chk("oor_ready", 64'(reqReady_o), 64'h1);
        next();
        reqValid_i = 2'b00;
        #1;
        chk("oor_wren",  64'(debugPRFWrEn_o), 64'd0);
        chk("oor_addr",  64'(debugPRFAddr_o), 64'd0);
        chk("oor_resp",  64'(respValid_o), 64'h1);
        chk("oor_err",   64'(respErr_o), 64'd1);
        chk("oor_rdata", respRData_o, 64'd0);
        next(); #1;
        chk("oor_idle", 64'(busy_o), 64'd0);

        // Reset during byte 3 of a requester-1 write to reg 20
        reqValid_i    = 2'b10;
        reqWe_i       = 2'b10;
        reqAddr_i[1]  = 6'd20;
        reqWData_i[1] = wd2;
        #1;
        chk("ab_ready", 64'(reqReady_o), 64'h2);
        for (int k = 1; k <= 3; k++) begin
            next();
            if (k == 1) reqValid_i = 2'b00;
        end
        next();
        reset = 1'b0;
        #1;
        chk("ab_wren", 64'(debugPRFWrEn_o), 64'd0);
        chk("ab_addr", 64'(debugPRFAddr_o), 64'd0);
        chk("ab_data", 64'(debugPRFWrData_o), 64'd0);
        chk("ab_busy", 64'(busy_o), 64'd0);
        for (int c = 0; c < 12; c++) begin
            next();
            if (c == 2) reset = 1'b1;
            #1;
            chk("ab_noresp", 64'(respValid_o), 64'd0);
        end
        for (int i = 0; i < 8; i++)
            chk("ab_mem", 64'(mem[20*8 + i]), (i < 3) ? ((wd2 >> (8*i)) & 64'hFF) : 64'd0);

        // Pointer back to favouring requester 0; read reg 20
        reqValid_i   = 2'b11;
        reqWe_i      = 2'b00;
        reqAddr_i[0] = 6'd20;
        reqAddr_i[1] = 6'd20;
        #1;
        chk("ab_gnt0", 64'(reqReady_o), 64'h1);
        for (int k = 1; k <= 10; k++) begin
            next();
            if (k == 1) reqValid_i = 2'b00;
        end
        #1;
        chk("ab_rd_resp",  64'(respValid_o), 64'h1);
        chk("ab_rd_rdata", respRData_o, wd2 & 64'hFF_FFFF);
        wait_idle("end_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
